inference_sequencer: RTL and testbench
======================================

# inference_sequencer

Host-facing controller that sits between the 32-bit host word and the sample memory / spiking network / output-layer datapath. It decodes tagged commands from `data_in`, loads 19-bit samples into memory, and runs one inference pass over the loaded samples. It waits for the output layer to settle and reports status and the winning class on `data_out`. It takes ownership of memory `read_en`/`write_en` and network clearing, which were previously driven ad hoc.

## Interface
Parameters:
- `DATA_W`, 19, sample/payload width (`data_in[18:0]`)
- `DEPTH`, 128, memory depth in samples
- `ADDR_W`, 7, log2(DEPTH)
- `RES_W`, 4, class-index width from output layer
- `TIMEOUT`, 1024, max cycles to wait for `settled` after the read phase

Ports:
- `clk` in 1: the single clock; all logic on rising edge
- `rstn` in 1: synchronous, active-high reset (the port name follows the codebase; polarity and synchronicity are fixed as stated)
- `data_in` in 32: [31:28] opcode, [27:19] tag, [18:0] payload
- `settled` in 1: output layer finished
- `result_in` in RES_W: winning class index, valid while `settled`
- `mem_write_en` out 1: one-cycle write strobe
- `mem_write_data` out DATA_W: payload; 0 when `mem_write_en` is low
- `mem_read_en` out 1: memory streams one sample per cycle while high
- `net_clr` out 1: one-cycle pulse clearing network/output-layer state
- `data_out` out 32: status word

## Operation
- Command acceptance: a command is accepted on the edge where `data_in[27:19]` differs from the last accepted tag. The tag register resets to 0, so the host starts at tag 1. An unchanged tag means no action. Every accepted command updates the ack tag, including rejected ones.
- Opcodes: 0 NOP, 1 WRITE, 2 RUN, 3 ABORT, 4 CLEAR_PTR. Opcodes 5–15 are rejected and set `error`.
- `count` (ADDR_W+1 bits) holds the number of loaded samples.
- States and transitions:
  - IDLE:
    - WRITE with `count < DEPTH` → LOAD.
    - WRITE with `count == DEPTH` → set `error`, no write.
    - RUN with `count == 0` → set `error`, stay IDLE.
    - RUN otherwise → CLR.
    - CLEAR_PTR → `count = 0`, clears `done`/`timeout`/`error`.
  - LOAD (1 cycle): `mem_write_en = 1`, `mem_write_data = latched payload`, `count += 1` → IDLE.
  - CLR (1 cycle): `net_clr = 1`, clears `done`/`timeout`, loads `rdcnt = count` → READ.
  - READ: `mem_read_en = 1` for exactly `count` cycles → DRAIN.
  - DRAIN: `settled` high → capture `result_in`, set `done` → IDLE. Waiting `TIMEOUT` cycles without `settled` → set `timeout` → IDLE.
- Busy states are LOAD, CLR, READ and DRAIN.
  - ABORT in any busy state → IDLE next cycle, with `net_clr` pulsed that cycle.
  - Any other accepted command while busy → `error`, no effect.
  - ABORT in IDLE is a NOP.
- `error` is sticky until CLEAR_PTR or reset.
- `data_out` layout:
  - [31:23] ack tag
  - [22] busy
  - [21] done
  - [20] timeout
  - [19] error
  - [18:11] count
  - [10:7] result
  - [6:0] zero

## Timing
- Reset drives every output and register to 0 (`data_out = 0`, all strobes low) and puts the FSM in IDLE, from any state.
- Command presented before edge k:
  - ack tag is visible after edge k;
  - `mem_write_en` is high for the cycle after edge k;
  - for RUN, `net_clr` is high for the cycle after edge k and `mem_read_en` is high for cycles k+2 … k+1+count.
- `settled` is sampled in DRAIN only; `settled` in other states is ignored.
- `settled` on the same edge as the last timeout cycle → `done` wins.
- ABORT accepted on the edge READ would finish → ABORT wins, with no DRAIN.
- A tag change while busy is still acked on that edge.

## Structure
- Shared package `seq_pkg`:
  - opcode constants;
  - state enum (IDLE, LOAD, CLR, READ, DRAIN);
  - `data_out` bit-position constants.
- One sub-module, `seq_cmd_decode`: tag-change detector and opcode decode, producing one-cycle `cmd_valid`, `opcode`, `payload`.
- The FSM, counters and status register live in `inference_sequencer`.

## Test plan
- WRITE tags 1,2,3 with payloads 0x00011, 0x00022, 0x00033 → three single-cycle `mem_write_en` pulses with those data; `data_out[18:11] = 3`, ack tag = 3.
- RUN (tag 4) after 3 writes, `settled` with `result_in = 7` five cycles into DRAIN → `net_clr` 1 cycle, `mem_read_en` exactly 3 cycles, then `done = 1`, `data_out[10:7] = 7`, busy = 0.
- 129 WRITEs → 128 strobes; the 129th sets `error`, count stays 128; CLEAR_PTR → count 0, `error` 0.
- RUN with count 0 → `error = 1`, no `net_clr`/`mem_read_en`; same tag repeated → no second ack action.
- RUN with `settled` held low → `timeout = 1` after 1024 DRAIN cycles; ABORT issued mid-READ on another run → `mem_read_en` drops next cycle, `net_clr` pulses, IDLE.
- Assert `rstn` mid-READ → next cycle all outputs 0, ack tag 0; tag 1 is accepted afterwards.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the inference sequencer: command opcodes, FSM states
// and the bit layout of the host status word.
package seq_pkg;

  localparam int unsigned TagW = 9;
  localparam int unsigned OpW  = 4;

  localparam logic [OpW-1:0] OpNop      = 4'd0;
  localparam logic [OpW-1:0] OpWrite    = 4'd1;
  localparam logic [OpW-1:0] OpRun      = 4'd2;
  localparam logic [OpW-1:0] OpAbort    = 4'd3;
  localparam logic [OpW-1:0] OpClearPtr = 4'd4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClr,
    StRead,
    StDrain
  } seq_state_e;

  localparam int unsigned AckTagLsb  = 23;
  localparam int unsigned BusyBit    = 22;
  localparam int unsigned DoneBit    = 21;
  localparam int unsigned TimeoutBit = 20;
  localparam int unsigned ErrorBit   = 19;
  localparam int unsigned CountLsb   = 11;
  localparam int unsigned ResultLsb  = 7;

endpackage

// File: rtl/seq_cmd_decode.sv
// Host command decoder: a command fires for one cycle whenever the tag field
// differs from the last accepted tag, which is then remembered as the ack tag.
module seq_cmd_decode
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_data,
  output logic              o_cmd_valid,
  output logic [OpW-1:0]    o_opcode,
  output logic [DATA_W-1:0] o_payload,
  output logic [TagW-1:0]   o_ack_tag
);

  logic [TagW-1:0] r_tag;
  logic [TagW-1:0] w_tag;
  logic            w_tag_changed;

  assign w_tag         = i_data[27:19];
  assign w_tag_changed = (w_tag != r_tag);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag <= '0;
    end else if (w_tag_changed) begin
      r_tag <= w_tag;
    end
  end

  assign o_cmd_valid = w_tag_changed;
  assign o_opcode    = i_data[31:28];
  assign o_payload   = i_data[DATA_W-1:0];
  assign o_ack_tag   = r_tag;

endmodule

// File: rtl/inference_sequencer.sv
// Host-facing sequencer: loads samples into memory, runs one inference pass
// over them and reports status plus the winning class on data_out.
module inference_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 19,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned RES_W   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       data_in,
  input  logic              settled,
  input  logic [RES_W-1:0]  result_in,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read_en,
  output logic              net_clr,
  output logic [31:0]       data_out
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  CntOne   = (ADDR_W + 1)'(1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);

  logic              w_cmd_valid;
  logic [OpW-1:0]    w_opcode;
  logic [DATA_W-1:0] w_payload;
  logic [TagW-1:0]   w_ack_tag;
  logic              w_busy;

  seq_state_e        r_state;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_rdcnt;
  logic [WaitW-1:0]  r_wait;
  logic              r_done;
  logic              r_timeout;
  logic              r_error;
  logic [RES_W-1:0]  r_result;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_rd_en;
  logic              r_net_clr;

  seq_cmd_decode #(
    .DATA_W(DATA_W)
  ) u_decode (
    .i_clk      (clk),
    .i_rst      (rstn),
    .i_data     (data_in),
    .o_cmd_valid(w_cmd_valid),
    .o_opcode   (w_opcode),
    .o_payload  (w_payload),
    .o_ack_tag  (w_ack_tag)
  );

  assign w_busy = (r_state != StIdle);

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_rdcnt   <= '0;
      r_wait    <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_error   <= 1'b0;
      r_result  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_net_clr <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_net_clr <= 1'b0;
      // ABORT pre-empts everything in a busy state, including the last READ edge.
      if (w_busy && w_cmd_valid && (w_opcode == OpAbort)) begin
        r_state   <= StIdle;
        r_rd_en   <= 1'b0;
        r_net_clr <= 1'b1;
      end else begin
        if (w_busy && w_cmd_valid) begin
          r_error <= 1'b1;
        end
        unique case (r_state)
          StIdle: begin
            if (w_cmd_valid) begin
              case (w_opcode)
                OpNop, OpAbort: begin
                end
                OpWrite: begin
                  if (r_count == DepthCnt) begin
                    r_error <= 1'b1;
                  end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= w_payload;
                    r_state   <= StLoad;
                  end
                end
                OpRun: begin
                  if (r_count == '0) begin
                    r_error <= 1'b1;
                  end else begin
                    r_net_clr <= 1'b1;
                    r_state   <= StClr;
                  end
                end
                OpClearPtr: begin
                  r_count   <= '0;
                  r_done    <= 1'b0;
                  r_timeout <= 1'b0;
                  r_error   <= 1'b0;
                end
                default: r_error <= 1'b1;
              endcase
            end
          end
          StLoad: begin
            r_count <= r_count + CntOne;
            r_state <= StIdle;
          end
          StClr: begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rdcnt   <= r_count;
            r_rd_en   <= 1'b1;
            r_state   <= StRead;
          end
          StRead: begin
            if (r_rdcnt == CntOne) begin
              r_rd_en <= 1'b0;
              r_wait  <= '0;
              r_state <= StDrain;
            end else begin
              r_rdcnt <= r_rdcnt - CntOne;
            end
          end
          StDrain: begin
            // settled is checked first so it wins over an expiring wait.
            if (settled) begin
              r_result <= result_in;
              r_done   <= 1'b1;
              r_state  <= StIdle;
            end else if (r_wait == WaitLast) begin
              r_timeout <= 1'b1;
              r_state   <= StIdle;
            end else begin
              r_wait <= r_wait + WaitOne;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    data_out = '0;
    data_out[AckTagLsb +: TagW]   = w_ack_tag;
    data_out[BusyBit]             = w_busy;
    data_out[DoneBit]             = r_done;
    data_out[TimeoutBit]          = r_timeout;
    data_out[ErrorBit]            = r_error;
    data_out[CountLsb +: ADDR_W+1] = r_count;
    data_out[ResultLsb +: RES_W]  = r_result;
  end

  assign mem_write_en   = r_wr_en;
  assign mem_write_data = r_wr_data;
  assign mem_read_en    = r_rd_en;
  assign net_clr        = r_net_clr;

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer: vector table, directed
// multi-cycle sequences and a randomized run against a command-level model.
module tb_inference_sequencer;

  localparam logic [3:0] CmdNop   = 4'd0;
  localparam logic [3:0] CmdWrite = 4'd1;
  localparam logic [3:0] CmdRun   = 4'd2;
  localparam logic [3:0] CmdAbort = 4'd3;
  localparam logic [3:0] CmdClear = 4'd4;
  localparam int Depth   = 128;
  localparam int Timeout = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] data_in;
  logic        settled;
  logic [3:0]  result_in;
  logic        mem_write_en;
  logic [18:0] mem_write_data;
  logic        mem_read_en;
  logic        net_clr;
  logic [31:0] data_out;

  always #5 clk = ~clk;

  inference_sequencer dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_in       (data_in),
    .settled       (settled),
    .result_in     (result_in),
    .mem_write_en  (mem_write_en),
    .mem_write_data(mem_write_data),
    .mem_read_en   (mem_read_en),
    .net_clr       (net_clr),
    .data_out      (data_out)
  );

  logic st_busy, st_done, st_to, st_err;
  logic [7:0] st_count;
  logic [8:0] st_ack;
  assign st_ack   = data_out[31:23];
  assign st_busy  = data_out[22];
  assign st_done  = data_out[21];
  assign st_to    = data_out[20];
  assign st_err   = data_out[19];
  assign st_count = data_out[18:11];

  int n_pass  = 0;
  int n_total = 0;
  logic [8:0] tag;
  int         m_count;
  logic       m_err, m_done, m_to;
  logic [3:0] m_res;

  typedef struct {
    logic [3:0]  op;
    logic [18:0] pl;
    logic        wr;
    int          cnt;
    logic        err;
  } vec_t;
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic [3:0] op, input logic [18:0] pl);
    tag = tag + 9'd1;
    data_in = {op, tag, pl};
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    data_in = '0;
    settled = 1'b0;
    result_in = '0;
    repeat (2) tick();
    rstn = 1'b0;
    tag = '0;
    m_count = 0; m_err = 0; m_done = 0; m_to = 0; m_res = '0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[31:23] = tag;
    s[21]    = m_done;
    s[20]    = m_to;
    s[19]    = m_err;
    s[18:11] = 8'(m_count);
    s[10:7]  = m_res;
    return s;
  endfunction

  // delay < 0: settled never rises and the run must time out.
  task automatic do_run(input int n, input int delay, input logic [3:0] res, input logic noise);
    int reads;
    int budget;
    int waited;
    send(CmdRun, '0);
    chk("run_net_clr", net_clr, 1);
    chk("run_clr_rd_en", mem_read_en, 0);
    chk("run_busy", st_busy, 1);
    chk("run_ack", st_ack, tag);
    settled = noise;
    tick();
    chk("run_net_clr_len", net_clr, 0);
    reads = 0;
    budget = n + 4;
    while (mem_read_en && budget > 0) begin
      reads++;
      budget--;
      settled = noise & 1'($urandom_range(0, 1));
      tick();
    end
    settled = 1'b0;
    chk("run_reads", reads, n);
    chk("run_drain_busy", st_busy, 1);
    if (delay < 0) begin
      waited = 0;
      while (st_busy && waited < Timeout + 50) begin
        waited++;
        tick();
      end
      chk("run_timeout_len", waited, Timeout);
      chk("run_timeout_bit", st_to, 1);
      chk("run_timeout_done", st_done, 0);
    end else begin
      repeat (delay) tick();
      chk("run_wait_busy", st_busy, 1);
      settled = 1'b1;
      result_in = res;
      tick();
      settled = 1'b0;
      result_in = 4'($urandom);
      chk("run_done", st_done, 1);
      chk("run_to_clear", st_to, 0);
      chk("run_result", data_out[10:7], res);
      chk("run_idle", st_busy, 0);
    end
    chk("run_rd_off", mem_read_en, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int strobes;
    logic [3:0]  op;
    logic [18:0] pl;
    logic        exp_wr;
    int          r;

    vecs[0] = '{CmdWrite, 19'h00011, 1'b1, 1, 1'b0};
    vecs[1] = '{CmdWrite, 19'h00022, 1'b1, 2, 1'b0};
    vecs[2] = '{CmdWrite, 19'h00033, 1'b1, 3, 1'b0};
    vecs[3] = '{CmdNop,   19'h12345, 1'b0, 3, 1'b0};
    vecs[4] = '{4'd9,     19'h00001, 1'b0, 3, 1'b1};
    vecs[5] = '{CmdAbort, 19'h00000, 1'b0, 3, 1'b1};
    vecs[6] = '{CmdClear, 19'h00000, 1'b0, 0, 1'b0};
    vecs[7] = '{CmdRun,   19'h00000, 1'b0, 0, 1'b1};
    vecs[8] = '{CmdClear, 19'h00000, 1'b0, 0, 1'b0};
    vecs[9] = '{CmdWrite, 19'h7ffff, 1'b1, 1, 1'b0};

    do_reset();
    chk("reset_status", data_out, 0);
    chk("reset_wr", mem_write_en, 0);
    chk("reset_rd", mem_read_en, 0);
    chk("reset_clr", net_clr, 0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].pl);
      chk($sformatf("vec%0d_wr_en", i), mem_write_en, vecs[i].wr);
      chk($sformatf("vec%0d_wr_data", i), mem_write_data, vecs[i].wr ? vecs[i].pl : 19'h0);
      chk($sformatf("vec%0d_net_clr", i), net_clr, 0);
      chk($sformatf("vec%0d_ack", i), st_ack, tag);
      tick();
      chk($sformatf("vec%0d_wr_pulse", i), mem_write_en, 0);
      chk($sformatf("vec%0d_rd", i), mem_read_en, 0);
      chk($sformatf("vec%0d_count", i), st_count, vecs[i].cnt);
      chk($sformatf("vec%0d_err", i), st_err, vecs[i].err);
    end

    // Same tag with a different opcode must not be acted on.
    data_in = {CmdRun, tag, 19'h0};
    repeat (3) begin
      tick();
      chk("same_tag_clr", net_clr, 0);
      chk("same_tag_busy", st_busy, 0);
    end

    send(CmdClear, '0);
    tick();
    send(CmdWrite, 19'h00011); tick();
    send(CmdWrite, 19'h00022); tick();
    send(CmdWrite, 19'h00033); tick();
    chk("three_count", st_count, 3);
    do_run(3, 4, 4'd7, 1'b0);
    do_run(3, Timeout - 1, 4'd5, 1'b1);
    do_run(3, -1, 4'd0, 1'b1);
    chk("after_runs_count", st_count, 3);

    for (int i = 0; i < 7; i++) begin
      send(CmdWrite, 19'(i)); tick();
    end
    send(CmdRun, '0);
    tick();
    send(CmdNop, '0);
    chk("busy_cmd_err", st_err, 1);
    chk("busy_cmd_rd", mem_read_en, 1);
    chk("busy_cmd_ack", st_ack, tag);
    tick();
    send(CmdAbort, '0);
    chk("abort_rd", mem_read_en, 0);
    chk("abort_clr", net_clr, 1);
    chk("abort_idle", st_busy, 0);
    chk("abort_ack", st_ack, tag);
    tick();
    chk("abort_clr_len", net_clr, 0);
    chk("abort_rd_off", mem_read_en, 0);

    send(CmdRun, '0);
    tick();
    repeat (9) tick();
    chk("last_read_rd", mem_read_en, 1);
    send(CmdAbort, '0);
    chk("abort_last_idle", st_busy, 0);
    chk("abort_last_clr", net_clr, 1);
    chk("abort_last_rd", mem_read_en, 0);
    repeat (3) tick();
    chk("abort_last_no_drain", st_busy, 0);
    chk("abort_last_no_done", st_done, 0);

    send(CmdClear, '0);
    tick();
    chk("clear_err", st_err, 0);
    chk("clear_count", st_count, 0);
    strobes = 0;
    for (int i = 0; i < Depth + 1; i++) begin
      send(CmdWrite, 19'(i + 1));
      strobes += int'(mem_write_en);
      tick();
    end
    chk("full_strobes", strobes, Depth);
    chk("full_count", st_count, Depth);
    chk("full_err", st_err, 1);
    send(CmdClear, '0);
    tick();
    chk("full_clear_count", st_count, 0);
    chk("full_clear_err", st_err, 0);

    for (int i = 0; i < 5; i++) begin
      send(CmdWrite, 19'(i)); tick();
    end
    send(CmdRun, '0);
    repeat (2) tick();
    chk("pre_reset_rd", mem_read_en, 1);
    rstn = 1'b1;
    data_in = '0;
    tick();
    chk("midrst_status", data_out, 0);
    chk("midrst_wr", mem_write_en, 0);
    chk("midrst_wr_data", mem_write_data, 0);
    chk("midrst_rd", mem_read_en, 0);
    chk("midrst_clr", net_clr, 0);
    rstn = 1'b0;
    tag = '0;
    send(CmdWrite, 19'h12345);
    chk("post_rst_ack", st_ack, 1);
    chk("post_rst_wr", mem_write_en, 1);
    chk("post_rst_wr_data", mem_write_data, 19'h12345);
    tick();

    do_reset();
    for (int it = 0; it < 250; it++) begin
      chk($sformatf("rand%0d_status", it), data_out, exp_status());
      r = $urandom_range(0, 99);
      if (r < 45)      op = CmdWrite;
      else if (r < 55) op = CmdClear;
      else if (r < 62) op = CmdNop;
      else if (r < 68) op = CmdAbort;
      else if (r < 75) op = 4'($urandom_range(5, 15));
      else             op = CmdRun;
      pl = 19'($urandom);
      if (op == CmdRun && m_count > 0) begin
        m_res = 4'($urandom);
        do_run(m_count, $urandom_range(0, 6), m_res, 1'b1);
        m_done = 1'b1;
        m_to = 1'b0;
      end else begin
        send(op, pl);
        exp_wr = (op == CmdWrite) && (m_count < Depth);
        chk("rand_wr_en", mem_write_en, exp_wr);
        if (exp_wr) chk("rand_wr_data", mem_write_data, pl);
        chk("rand_net_clr", net_clr, 0);
        tick();
        if (exp_wr) m_count++;
        else if (op == CmdWrite || op == CmdRun || op > CmdClear) m_err = 1'b1;
        else if (op == CmdClear) begin
          m_count = 0; m_err = 0; m_done = 0; m_to = 0;
        end
      end
    end
    chk("rand_final_status", data_out, exp_status());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
